// File: rtl/jr_hazard_ctrl.sv
// JR hazard controller: tracks destination tags in EX/MEM/WB, selects the forwarding
// source for a JR/JALR in ID and stalls while the youngest producer is an unfinished load.
module jr_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ext_hold,
    input  logic              id_valid,
    input  logic              id_is_jr,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_dst_we,
    input  logic [REG_AW-1:0] id_dst_addr,
    input  logic              id_is_load,
    output logic              stall,
    output logic              bubble,
    output logic              flush_if,
    output logic              jr_take,
    output logic [1:0]        fwd_sel
);

    // state   | meaning
    // S_IDLE  | no stall sequence in progress; JR resolves or hazard is detected here
    // S_STALL | load was in EX when JR arrived; cnt counts remaining stall cycles
    typedef enum logic {S_IDLE, S_STALL} state_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL - 2);

    state_t            state;
    logic [1:0]        cnt;

    logic              ex_v, mem_v, wb_v;
    logic [REG_AW-1:0] ex_a, mem_a, wb_a;
    logic              ex_l, mem_l, wb_l;

    logic              rs_nz;
    logic              ex_match, mem_match, wb_match;
    logic              jr_req, haz_ex, haz_mem, haz;

    assign rs_nz     = (id_rs != '0);
    assign ex_match  = ex_v  && (ex_a  == id_rs) && rs_nz;
    assign mem_match = mem_v && (mem_a == id_rs) && rs_nz;
    assign wb_match  = wb_v  && (wb_a  == id_rs) && rs_nz;

    assign jr_req  = id_valid && id_is_jr;
    // Only the youngest producer matters: an ALU result in EX shadows an older load in MEM.
    assign haz_ex  = jr_req && ex_match && ex_l;
    assign haz_mem = jr_req && !ex_match && mem_match && mem_l;
    assign haz     = haz_ex || haz_mem;

    always_comb begin
        if (ex_match)       fwd_sel = 2'd1;
        else if (mem_match) fwd_sel = 2'd2;
        else if (wb_match)  fwd_sel = 2'd3;
        else                fwd_sel = 2'd0;
    end

    // Outputs are decoded from current state so a clean JR resolves with no added latency.
    always_comb begin
        stall    = 1'b0;
        bubble   = 1'b0;
        jr_take  = 1'b0;
        flush_if = 1'b0;
        if (!reset_n) begin
            stall = 1'b0;
        end else if (ext_hold) begin
            stall = 1'b1;
        end else if (state == S_STALL || haz) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end else if (jr_req) begin
            jr_take  = 1'b1;
            flush_if = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
            ex_v  <= 1'b0;
            ex_a  <= '0;
            ex_l  <= 1'b0;
            mem_v <= 1'b0;
            mem_a <= '0;
            mem_l <= 1'b0;
            wb_v  <= 1'b0;
            wb_a  <= '0;
            wb_l  <= 1'b0;
        end else if (!ext_hold) begin
            wb_v  <= mem_v;
            wb_a  <= mem_a;
            wb_l  <= mem_l;
            mem_v <= ex_v;
            mem_a <= ex_a;
            mem_l <= ex_l;
            if (id_valid && id_dst_we && !stall) begin
                ex_v <= 1'b1;
                ex_a <= id_dst_addr;
                ex_l <= id_is_load;
            end else begin
                ex_v <= 1'b0;
                ex_a <= '0;
                ex_l <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (haz_ex) begin
                        state <= S_STALL;
                        cnt   <= CNT_INIT;
                    end
                end
                S_STALL: begin
                    if (cnt == 2'd0) state <= S_IDLE;
                    else             cnt   <= cnt - 2'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jr_hazard_ctrl.sv
// Directed bench for jr_hazard_ctrl: a pipeline-occupancy model predicts every output each
// cycle, and literal checks at key points pin the model to hand-computed values.
module tb_jr_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ext_hold = 1'b0;
    logic       id_valid = 1'b0;
    logic       id_is_jr = 1'b0;
    logic [4:0] id_rs = '0;
    logic       id_dst_we = 1'b0;
    logic [4:0] id_dst_addr = '0;
    logic       id_is_load = 1'b0;
    logic       stall, bubble, flush_if, jr_take;
    logic [1:0] fwd_sel;

    int total = 0;
    int bad = 0;

    jr_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(2)) dut (
        .clk(clk), .reset_n(reset_n), .ext_hold(ext_hold),
        .id_valid(id_valid), .id_is_jr(id_is_jr), .id_rs(id_rs),
        .id_dst_we(id_dst_we), .id_dst_addr(id_dst_addr), .id_is_load(id_is_load),
        .stall(stall), .bubble(bubble), .flush_if(flush_if), .jr_take(jr_take),
        .fwd_sel(fwd_sel)
    );

    always #5 clk = ~clk;

    // Model: index 0=EX, 1=MEM, 2=WB. A JR waits while its youngest producer is a load
    // that has not yet reached WB; otherwise it resolves at once.
    logic       pv[3];
    logic [4:0] pa[3];
    logic       pl[3];
    logic       m_stall, m_bubble, m_jr;
    logic [1:0] m_fwd;

    task automatic model_eval();
        int  k;
        logic haz;
        k = 3;
        for (int i = 2; i >= 0; i--)
            if (pv[i] && pa[i] == id_rs && id_rs != 5'd0) k = i;
        m_fwd = (k == 3) ? 2'd0 : 2'(k + 1);
        haz = 1'b0;
        if (k < 2) haz = id_valid && id_is_jr && pl[k];
        m_stall  = ext_hold || haz;
        m_bubble = haz && !ext_hold;
        m_jr     = !ext_hold && !haz && id_valid && id_is_jr;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] = 1'b0; pa[i] = '0; pl[i] = 1'b0;
            end
        end else if (!ext_hold) begin
            model_eval();
            for (int i = 2; i > 0; i--) begin
                pv[i] = pv[i-1]; pa[i] = pa[i-1]; pl[i] = pl[i-1];
            end
            pv[0] = id_valid && id_dst_we && !m_stall;
            pa[0] = pv[0] ? id_dst_addr : 5'd0;
            pl[0] = pv[0] && id_is_load;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            model_eval();
            total++;
            if (stall !== m_stall || bubble !== m_bubble || jr_take !== m_jr ||
                flush_if !== m_jr || fwd_sel !== m_fwd) begin
                bad++;
                $display("FAIL model t=%0t got stall=%b bubble=%b jr=%b flush=%b fwd=%0d want stall=%b bubble=%b jr=%b flush=%b fwd=%0d",
                         $time, stall, bubble, jr_take, flush_if, fwd_sel,
                         m_stall, m_bubble, m_jr, m_jr, m_fwd);
            end
        end
    end

    task automatic lit(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic j, input int rs, input logic we,
                       input int dst, input logic ld, input logic h);
        @(posedge clk);
        #1;
        id_valid = v; id_is_jr = j; id_rs = 5'(rs);
        id_dst_we = we; id_dst_addr = 5'(dst); id_is_load = ld; ext_hold = h;
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic alu(input int d);  cyc(1'b1, 1'b0, 0, 1'b1, d, 1'b0, 1'b0); endtask
    task automatic lw(input int d);   cyc(1'b1, 1'b0, 0, 1'b1, d, 1'b1, 1'b0); endtask
    task automatic jr(input int r);   cyc(1'b1, 1'b1, r, 1'b0, 0, 1'b0, 1'b0); endtask
    task automatic jrh(input int r);  cyc(1'b1, 1'b1, r, 1'b0, 0, 1'b0, 1'b1); endtask

    initial begin
        int stalls;
        #12;
        lit("reset_stall", int'(stall), 0);
        lit("reset_fwd", int'(fwd_sel), 0);
        reset_n = 1'b1;
        nop(1);

        alu(5); jr(5);
        lit("alu_stall", int'(stall), 0);
        lit("alu_jr", int'(jr_take), 1);
        lit("alu_flush", int'(flush_if), 1);
        lit("alu_fwd", int'(fwd_sel), 1);
        nop(3);

        lw(5); jr(5);
        lit("ldex_stall1", int'(stall), 1);
        lit("ldex_bubble1", int'(bubble), 1);
        jr(5);
        lit("ldex_stall2", int'(stall), 1);
        lit("ldex_bubble2", int'(bubble), 1);
        jr(5);
        lit("ldex_jr", int'(jr_take), 1);
        lit("ldex_fwd", int'(fwd_sel), 3);
        nop(3);

        lw(7); nop(1); jr(7);
        lit("ldmem_stall", int'(stall), 1);
        lit("ldmem_fwd", int'(fwd_sel), 2);
        jr(7);
        lit("ldmem_jr", int'(jr_take), 1);
        lit("ldmem_fwd3", int'(fwd_sel), 3);
        nop(3);

        lw(0); jr(0);
        lit("zero_stall", int'(stall), 0);
        lit("zero_fwd", int'(fwd_sel), 0);
        nop(3);

        lw(4); alu(4); jr(4);
        lit("prio_fwd", int'(fwd_sel), 1);
        lit("prio_stall", int'(stall), 0);
        lit("prio_jr", int'(jr_take), 1);
        nop(3);

        alu(3);
        cyc(1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
        lit("novalid_fwd", int'(fwd_sel), 1);
        lit("novalid_ctl", int'({stall, bubble, jr_take, flush_if}), 0);
        nop(3);

        jr(2);
        lit("b2b_jr1", int'(jr_take), 1);
        jr(2);
        lit("b2b_jr2", int'(jr_take), 1);
        nop(3);

        stalls = 0;
        lw(5); jr(5);
        stalls += int'(stall);
        for (int i = 0; i < 3; i++) begin
            jrh(5);
            stalls += int'(stall);
            lit("hold_bubble", int'(bubble), 0);
            lit("hold_fwd", int'(fwd_sel), 2);
        end
        jr(5);
        stalls += int'(stall);
        jr(5);
        lit("hold_stalls", stalls, 5);
        lit("hold_jr", int'(jr_take), 1);
        lit("hold_fwd3", int'(fwd_sel), 3);
        nop(3);

        lw(8); jr(8); jr(8);
        lit("rst_pre_stall", int'(stall), 1);
        #1 reset_n = 1'b0;
        #1;
        lit("rst_stall", int'(stall), 0);
        lit("rst_fwd", int'(fwd_sel), 0);
        lit("rst_bubble", int'(bubble), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        jr(9);
        lit("rst_jr", int'(jr_take), 1);
        lit("rst_jr_fwd", int'(fwd_sel), 0);
        nop(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
